// File: rtl/lmg_move_collector_pkg.sv
// Shared definitions for the legal-move collector: column codes, move-word layout and FSM states.
package lmg_move_collector_pkg;

  localparam logic [2:0] COLA = 3'o0;
  localparam logic [2:0] COLB = 3'o1;
  localparam logic [2:0] COLC = 3'o2;
  localparam logic [2:0] COLD = 3'o3;
  localparam logic [2:0] COLE = 3'o4;
  localparam logic [2:0] COLF = 3'o5;
  localparam logic [2:0] COLG = 3'o6;
  localparam logic [2:0] COLH = 3'o7;

  localparam int MOVE_W     = 12;
  localparam int FROM_X_LSB = 9;
  localparam int FROM_Y_LSB = 6;
  localparam int TO_X_LSB   = 3;
  localparam int TO_Y_LSB   = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [MOVE_W-1:0] pack_move(input logic [2:0] fx, input logic [2:0] fy,
                                                  input logic [2:0] tx, input logic [2:0] ty);
    return {fx, fy, tx, ty};
  endfunction

endpackage

// File: rtl/lmg_move_collector_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer; pointer moves past the winner.
module lmg_move_collector_rr_arbiter #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Priority scan starting at the pointer, wrapping through all N requesters.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end else begin
        found = found;
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/lmg_move_collector.sv
// Collects moves from the column units by round-robin, buffers them in a FIFO and
// presents one valid/ready stream with per-board move count and completion flag.
module lmg_move_collector
  import lmg_move_collector_pkg::*;
#(
  parameter int NCOL  = 8,
  parameter int DEPTH = 256,
  parameter int CW    = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   newboard,
  input  logic [NCOL-1:0]        col_valid,
  input  logic [MOVE_W*NCOL-1:0] col_move,
  input  logic [NCOL-1:0]        col_done,
  output logic [NCOL-1:0]        col_ready,
  output logic                   out_valid,
  output logic [MOVE_W-1:0]      out_move,
  input  logic                   out_ready,
  output logic [CW-1:0]          move_count,
  output logic                   all_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NCOL > 1) ? $clog2(NCOL) : 1;

  state_t            state;
  logic [NCOL-1:0]   sticky;
  logic [AW:0]       count;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [MOVE_W-1:0] mem [DEPTH];
  logic [MOVE_W-1:0] last_move;
  logic [MOVE_W-1:0] push_move;
  logic [IW-1:0]     gnt_idx;
  logic              grant_en;
  logic              push;
  logic              pop;

  // Grants never look at out_ready: only the registered occupancy gates them.
  assign grant_en  = !reset && !newboard && (state == S_COLLECT) && (count < (AW+1)'(DEPTH));
  assign push      = |col_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_move  = out_valid ? mem[rd_ptr] : last_move;

  lmg_move_collector_rr_arbiter #(.N(NCOL)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .clr     (newboard),
    .req     (col_valid),
    .en      (grant_en),
    .gnt     (col_ready),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    push_move = '0;
    for (int i = 0; i < NCOL; i++) begin
      if (gnt_idx == IW'(i)) begin
        push_move = col_move[MOVE_W*i +: MOVE_W];
      end else begin
        push_move = push_move;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_move;
    end
  end

  // last_move keeps the most recently presented head so out_move holds while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      last_move <= '0;
    end else if (newboard) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (out_valid) begin
        last_move <= mem[rd_ptr];
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_move <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (!push && pop) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sticky     <= '0;
      move_count <= '0;
      all_done   <= 1'b0;
    end else if (newboard) begin
      state      <= S_COLLECT;
      sticky     <= '0;
      move_count <= '0;
      all_done   <= 1'b0;
    end else begin
      if (push && (move_count != {CW{1'b1}})) begin
        move_count <= move_count + CW'(1);
      end
      case (state)
        S_IDLE: all_done <= 1'b0;
        S_COLLECT: begin
          sticky <= sticky | col_done;
          if ((&sticky) && (col_valid == '0)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count == '0) begin
            state    <= S_DONE;
            all_done <= 1'b1;
          end
        end
        S_DONE: all_done <= 1'b1;
        default: begin
          state    <= S_IDLE;
          all_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
